// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl : multicycle ARM control unit (FSM, decoder, NZCV flags, condition)
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN : illegal decodes enter a sticky TRAP
// Revision 1.0
// ============================================================================
module mc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl,
   output logic        Illegal
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ,TRAP  = 4'd10
`endif
   } state_t;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   localparam state_t ILL_NEXT = TRAP;
`else
   localparam state_t ILL_NEXT = FETCH;
`endif

   typedef struct packed {
      logic       irw;
      logic       pcw;
      logic       adr;
      logic       regw;
      logic       memw;
      logic       aluop;
      logic       branch;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] res;
   } ctl_t;

   function automatic ctl_t moore(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.irw = 1'b1; c.pcw = 1'b1; c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
         DECODE: begin c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
         MEMADR: c.srcb = 2'b01;
         MEMRD:  c.adr = 1'b1;
         MEMWB:  begin c.res = 2'b01; c.regw = 1'b1; end
         MEMWR:  begin c.adr = 1'b1; c.memw = 1'b1; end
         EXECR:  c.aluop = 1'b1;
         EXECI:  begin c.srcb = 2'b01; c.aluop = 1'b1; end
         ALUWB:  c.regw = 1'b1;
         BRANCH: begin c.srcb = 2'b01; c.res = 2'b10; c.branch = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cond;
   logic [3:0] cmd;
   logic       s_bit;
   logic       dp_ok;
   logic       cond_ex;
   logic       n_f, z_f, c_f, v_f;
   logic [1:0] alu_dec;

   state_t     state_q, state_d;
   ctl_t       ctl_q, ctl_d;
   logic [3:0] flags_q, flags_d;
   logic       condexr_q, condexr_d;
   logic       illegal_q, illegal_d;

   logic       unused_ok;
   assign unused_ok = ^Instr[11:0];

   always_comb begin
      op      = Instr[27:26];
      funct   = Instr[25:20];
      rd      = Instr[15:12];
      cond    = Instr[31:28];
      cmd     = funct[4:1];
      s_bit   = funct[0];
      dp_ok   = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
      {n_f, z_f, c_f, v_f} = flags_q;

      case (cond)
         4'b0000: cond_ex = z_f;
         4'b0001: cond_ex = !z_f;
         4'b0010: cond_ex = c_f;
         4'b0011: cond_ex = !c_f;
         4'b0100: cond_ex = n_f;
         4'b0101: cond_ex = !n_f;
         4'b0110: cond_ex = v_f;
         4'b0111: cond_ex = !v_f;
         4'b1000: cond_ex = c_f && !z_f;
         4'b1001: cond_ex = !c_f || z_f;
         4'b1010: cond_ex = (n_f == v_f);
         4'b1011: cond_ex = (n_f != v_f);
         4'b1100: cond_ex = !z_f && (n_f == v_f);
         4'b1101: cond_ex = z_f || (n_f != v_f);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase

      case (cmd)
         4'b0010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         default: alu_dec = 2'b00;
      endcase

      state_d = state_q;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (op)
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               2'b00:   state_d = !dp_ok ? ILL_NEXT : (funct[5] ? EXECI : EXECR);
               default: state_d = ILL_NEXT;
            endcase
         end
         MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = FETCH;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
         ALUWB:  state_d = FETCH;
         BRANCH: state_d = FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         TRAP:   state_d = TRAP;
`endif
         default: state_d = FETCH;
      endcase
      ctl_d = moore(state_d);

      // Flag writes use the condition latched at DECODE, not the live flags.
      flags_d = flags_q;
      if (ctl_q.aluop && s_bit && condexr_q) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (cmd == 4'b0100 || cmd == 4'b0010)
            flags_d[1:0] = ALUFlags[1:0];
      end

      condexr_d = (state_q == DECODE) ? cond_ex : condexr_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q || (state_d == TRAP);
`else
      illegal_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         ctl_q     <= moore(FETCH);
         flags_q   <= 4'b0000;
         condexr_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctl_q     <= ctl_d;
         flags_q   <= flags_d;
         condexr_q <= condexr_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      IRWrite    = reset & ctl_q.irw;
      RegWrite   = reset & ctl_q.regw & condexr_q;
      MemWrite   = reset & ctl_q.memw & condexr_q;
      PCWrite    = reset & (ctl_q.pcw | (ctl_q.branch & condexr_q) |
                            (ctl_q.regw & condexr_q & (rd == 4'd15)));
      AdrSrc     = ctl_q.adr;
      ALUSrcA    = ctl_q.srca;
      ALUSrcB    = ctl_q.srcb;
      ResultSrc  = ctl_q.res;
      ImmSrc     = op;
      RegSrc     = {op == 2'b01, op == 2'b10};
      ALUControl = ctl_q.aluop ? alu_dec : 2'b00;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      Illegal    = illegal_q;
`else
      Illegal    = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// Scoreboard bench for mc_ctrl: directed test-plan cases then random instructions.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Instr = 32'h0;
   logic [3:0]  ALUFlags = 4'h0;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, memw, regw, irw, adr;
      logic [1:0] regsrc, srca, srcb, res, imm, aluctl;
      logic       illegal;
   } vec_t;

   typedef struct {
      vec_t  v;
      bit    rst_only;
      int    step;
      int    idx;
   } exp_t;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                  S_TRAP = 10, S_RST = 11;

   exp_t     sb[$];
   int       vectors = 0;
   int       miscompares = 0;
   logic [3:0] mflags = 4'h0;
   int       instr_idx = 0;

   function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   function automatic bit is_legal(input logic [31:0] ins);
      logic [3:0] cmd;
      cmd = ins[24:21];
      if (ins[27:26] == 2'b11) return 1'b0;
      if (ins[27:26] == 2'b00)
         return (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
      return 1'b1;
   endfunction

   function automatic vec_t expect_step(input int st, input logic [31:0] ins, input bit pass);
      vec_t e;
      logic [1:0] op;
      bit rd15;
      op   = ins[27:26];
      rd15 = (ins[15:12] == 4'hF);
      e = '0;
      e.imm    = op;
      e.regsrc = {op == 2'b01, op == 2'b10};
      case (st)
         S_FETCH:  begin e.irw = 1; e.pcw = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
         S_DECODE: begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
         S_MEMADR: e.srcb = 2'b01;
         S_MEMRD:  e.adr = 1;
         S_MEMWB:  begin e.res = 2'b01; e.regw = pass; e.pcw = pass && rd15; end
         S_MEMWR:  begin e.adr = 1; e.memw = pass; end
         S_EXECR, S_EXECI: begin
            if (st == S_EXECI) e.srcb = 2'b01;
            case (ins[24:21])
               4'd4:    e.aluctl = 2'b00;
               4'd2:    e.aluctl = 2'b01;
               4'd0:    e.aluctl = 2'b10;
               default: e.aluctl = 2'b11;
            endcase
         end
         S_ALUWB:  begin e.regw = pass; e.pcw = pass && rd15; end
         S_BRANCH: begin e.srcb = 2'b01; e.res = 2'b10; e.pcw = pass; end
         S_TRAP:   e.illegal = 1;
         default:  e = e;
      endcase
      return e;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [3:0] af, input logic rst,
                        input vec_t e, input bit rst_only, input int st);
      exp_t x;
      Instr = ins; ALUFlags = af; reset = rst;
      x.v = e; x.rst_only = rst_only; x.step = st; x.idx = instr_idx;
      sb.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic reset_cycle(input logic [31:0] ins);
      drive(ins, 4'($urandom), 1'b0, '0, 1'b1, S_RST);
      mflags = 4'h0;
   endtask

   // Runs one instruction; abort_at >= 0 replaces that step with a reset cycle.
   task automatic run_instr(input logic [31:0] ins, input bit use_xf, input logic [3:0] xf,
                            input int abort_at);
      int  seq[$];
      bit  pass;
      bit  sbit;
      logic [3:0] af;
      instr_idx++;
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      if (!is_legal(ins)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         for (int t = 0; t < 4; t++) seq.push_back(S_TRAP);
         seq.push_back(S_RST);
`endif
      end else if (ins[27:26] == 2'b01) begin
         seq.push_back(S_MEMADR);
         if (ins[20]) begin seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
         else seq.push_back(S_MEMWR);
      end else if (ins[27:26] == 2'b10) begin
         seq.push_back(S_BRANCH);
      end else begin
         seq.push_back(ins[25] ? S_EXECI : S_EXECR);
         seq.push_back(S_ALUWB);
      end
      pass = 1'b0;
      sbit = ins[20] && (ins[27:26] == 2'b00);
      for (int k = 0; k < seq.size(); k++) begin
         if (k == abort_at || seq[k] == S_RST) begin
            reset_cycle(ins);
            return;
         end
         if (seq[k] == S_DECODE) pass = cond_pass(ins[31:28], mflags);
         af = 4'($urandom);
         if ((seq[k] == S_EXECR || seq[k] == S_EXECI) && use_xf) af = xf;
         drive(ins, af, 1'b1, expect_step(seq[k], ins, pass), 1'b0, seq[k]);
         if ((seq[k] == S_EXECR || seq[k] == S_EXECI) && sbit && pass) begin
            mflags[3:2] = af[3:2];
            if (ins[24:21] == 4'd4 || ins[24:21] == 4'd2) mflags[1:0] = af[1:0];
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [3:0]  cmds [4];
      int kind;
      cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12;
      r = $urandom;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) r[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
      if (kind <= 4) begin
         r[27:26] = 2'b00;
         r[24:21] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 3)];
      end else if (kind <= 6) r[27:26] = 2'b01;
      else if (kind <= 8) r[27:26] = 2'b10;
      else r[27:26] = 2'b11;
      return r;
   endfunction

   // Monitor: pops one expectation per cycle and compares away from the active edge.
   initial begin
      exp_t x;
      vec_t act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal};
            vectors++;
            if (x.rst_only) begin
               if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
                  miscompares++;
                  $display("FAIL reset_enables instr#%0d got pc/mem/reg/ir=%b required 0000",
                           x.idx, {PCWrite, MemWrite, RegWrite, IRWrite});
               end
            end else if (act !== x.v) begin
               miscompares++;
               $display("FAIL outputs instr#%0d step=%0d instr=%h got=%b required=%b",
                        x.idx, x.step, Instr, act, x.v);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk); #1;
      reset_cycle(32'h0);
      reset_cycle(32'h0);
      run_instr(32'hE0821003, 0, 4'h0, -1);
      run_instr(32'hE0500000, 1, 4'b0110, -1);
      run_instr(32'h10821003, 0, 4'h0, -1);
      run_instr(32'hE5921004, 0, 4'h0, -1);
      run_instr(32'hE5821004, 0, 4'h0, -1);
      run_instr(32'hEAFFFFFE, 0, 4'h0, -1);
      run_instr(32'hE0500000, 1, 4'b0000, -1);
      run_instr(32'h0AFFFFFE, 0, 4'h0, -1);
      run_instr(32'hE091F003, 1, 4'b1001, -1);
      run_instr(32'hEC000000, 0, 4'h0, -1);
      run_instr(32'hE5821004, 0, 4'h0, 3);
      run_instr(32'hE0821003, 0, 4'h0, -1);
      for (int i = 0; i < 300; i++)
         run_instr(rand_instr(), 0, 4'h0, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain %0d expectations left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the ARM multicycle processor. It sequences the shared datapath (PC register, address mux, instruction register, register file, single ALU) through fetch, decode, execute, memory and writeback cycles. It decodes the latched instruction, holds the NZCV flags and evaluates the condition field. It drives every datapath select and write-enable plus the memory write strobe.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge initialises the block.
- Instr  in  32  instruction register output; bits 31:12 are used.
- ALUFlags  in  4  NZCV from the ALU (bit3=N, bit0=V).
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  0=PC, 1=Result.
- RegSrc  out  2  [0]=1 selects R15 for RA1; [1]=1 selects Rd for RA2.
- ALUSrcA  out  2  00=A register, 01=PC; 1x is unused and never driven.
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Op (Instr[27:26]).
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- Illegal  out  1  sticky undefined-instruction indicator.

## Operation
- Decode fields: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28], cmd=Funct[4:1], S=Funct[0].
- FSM states and transitions:
  - FETCH → DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00 with Funct[5]=0 → EXECR.
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11, or a DP cmd not in {0100,0010,0000,1100} → illegal handling (see Configuration).
  - MEMADR → MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR and EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Moore outputs per state (signals not listed are 0/00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
- RegSrc[0] = (Op==10); RegSrc[1] = (Op==01).
- ALUControl:
  - When ALUOp=1: decoded from cmd (0100→00, 0010→01, 0000→10, 1100→11).
  - Otherwise 00.
- FlagWrite: [1] (NZ) = ALUOp & S; [0] (CV) = ALUOp & S & (cmd==ADD or SUB).
- Condition logic:
  - CondEx is computed from the Flags register and Cond (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 gives 0).
  - CondExR latches CondEx at the end of DECODE and is held until the next DECODE.
- Gated outputs:
  - RegWrite = RegW & CondExR.
  - MemWrite = MemW & CondExR.
  - PCWrite = FETCH | (Branch & CondExR) | (RegW & CondExR & Rd==15).
- Flags update: Flags[3:2] ← ALUFlags[3:2] when FlagWrite[1] & CondExR; Flags[1:0] ← ALUFlags[1:0] when FlagWrite[0] & CondExR. Updates happen at the end of EXECR/EXECI only.

## Timing
- Reset:
  - State=FETCH.
  - Flags=0000, CondExR=0, Illegal=0.
  - While reset=0, PCWrite, RegWrite, MemWrite and IRWrite are forced to 0.
  - The first fetch occurs on the first edge after reset returns to 1.
- Cycles per instruction: LDR 5, STR 4, DP 4, B 3, failed-condition instructions the same as passing ones (writes suppressed only).
- Reset asserted mid-instruction: the FSM goes to FETCH at that edge; no write enable is asserted in that cycle.
- A flag update in EXECR does not affect the same instruction's ALUWB gating, because CondExR is already latched.
- Illegal is registered and rises one cycle after DECODE.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal decode enters TRAP.
  - TRAP asserts no enables and sets Illegal=1.
  - TRAP holds until reset.
- Not defined:
  - An illegal decode goes DECODE → FETCH as a NOP.
  - No TRAP state exists; Illegal is constant 0.

## Test plan
- Reset then ADD R1,R2,R3 (Instr=E0821003) → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
- SUBS R0,R0,R0 (E0500000) with ALUFlags=0110 in EXECR → Flags=0110. A following ADDNE (10821003) completes in 4 cycles with RegWrite=0 in ALUWB.
- LDR (E5921004) → MEMRD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1. STR (E5821004) → MEMWR has MemWrite=1, 4 cycles total.
- B (EAFFFFFE) → BRANCH has PCWrite=1, ALUSrcB=01, RegSrc[0]=1. BEQ with Z=0 → PCWrite=0 in BRANCH.
- Instr=EC000000 (Op=11):
  - With MC_CTRL_ILLEGAL_TRAP_EN, Illegal=1 and no further IRWrite until reset=0.
  - Without it, FETCH follows DECODE and Illegal stays 0.
- reset=0 asserted during MEMWR → MemWrite=0 that cycle; state=FETCH after reset is released.
